// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers:
// default field width, the nop encoding used as the bubble word,
// field slot indices and a field extraction helper.
package pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int NUM_FIELDS_DEF = 5;

  // sll $0,$0,0 encodes as all zeros, so a zeroed stage is a nop
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int F_INSTR = 0;
  localparam int F_PC    = 1;
  localparam int F_ALU   = 2;
  localparam int F_MEMRD = 3;
  localparam int F_LUI   = 4;

  // Pull one DATA_W_DEF-wide field out of a default-sized flat bus
  function automatic logic [DATA_W_DEF-1:0] field_sel(
    input logic [DATA_W_DEF*NUM_FIELDS_DEF-1:0] bus,
    input int                                   idx
  );
    return bus[idx*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// One-entry skid register for pipe_stage_reg. Holds a word that was
// accepted while the main entry was full and blocked downstream.
module pipe_skid_buf #(
  parameter int           W         = 160,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: clear beats hold; load and unload never coincide
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (!hold_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else if (unload_i) begin
        valid_d = 1'b0;
        data_d  = RESET_VAL;
      end
    end
  end

  // Skid entry storage with asynchronous clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with valid/ready
// handshake, hazard stall, synchronous flush, bubble insertion and a
// saturating bubble counter.
// Define PIPE_SKID_EN to add a second (skid) entry and make in_ready
// independent of out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                NUM_FIELDS  = NUM_FIELDS_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_WORD = DATA_W'(NOP_WORD),
  parameter int                CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*NUM_FIELDS-1:0] out_data,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int           W          = DATA_W * NUM_FIELDS;
  localparam logic [W-1:0] BUBBLE_BUS = {NUM_FIELDS{BUBBLE_WORD}};

  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             bubble_ev;

`ifdef PIPE_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         skid_load;
  logic         skid_unload;

  // Registered ready: only the skid occupancy and stall gate it
  assign in_ready = !stall && !skid_valid;
  assign accept   = in_valid && in_ready;

  assign skid_load   = !flush && !stall && valid_q && !out_ready && accept;
  assign skid_unload = !flush && !stall && valid_q && out_ready && skid_valid;

  pipe_skid_buf #(
    .W         (W),
    .RESET_VAL (BUBBLE_BUS)
  ) u_skid (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (flush),
    .hold_i   (stall),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (in_data),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  // Main entry next-state: skid refills main ahead of new input (FIFO order)
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    bubble_ev = 1'b0;
    if (flush) begin
      valid_d   = 1'b0;
      data_d    = BUBBLE_BUS;
      bubble_ev = valid_q;
    end else if (!stall) begin
      if (valid_q && out_ready) begin
        if (skid_valid) begin
          data_d = skid_data;
        end else if (accept) begin
          data_d = in_data;
        end else begin
          valid_d   = 1'b0;
          data_d    = BUBBLE_BUS;
          bubble_ev = 1'b1;
        end
      end else if (!valid_q && accept) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end
    end
  end
`else
  // Combinational ready: a consuming downstream frees the slot this cycle
  assign in_ready = !stall && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Main entry next-state: flush, then stall, then accept or drain
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    bubble_ev = 1'b0;
    if (flush) begin
      valid_d   = 1'b0;
      data_d    = BUBBLE_BUS;
      bubble_ev = valid_q;
    end else if (!stall) begin
      if (accept) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (valid_q && out_ready) begin
        valid_d   = 1'b0;
        data_d    = BUBBLE_BUS;
        bubble_ev = 1'b1;
      end
    end
  end
`endif

  // Saturating bubble counter next-state
  always_comb begin
    cnt_d = cnt_q;
    if (bubble_ev && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Main entry and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_BUS;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (builds with or without PIPE_SKID_EN).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW   = 32;
  localparam int NF   = 5;
  localparam int W    = DW * NF;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W      (DW),
    .NUM_FIELDS  (NF),
    .BUBBLE_WORD (32'h0),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit           st, fl, iv, orr;
    logic [W-1:0] din;
    bit           e_rdy, e_val;
    logic [W-1:0] e_data;
    int           e_cnt;
  } vec_t;

  vec_t tbl[12];

  // Reference model: ordered list of held words plus bubble tally
  logic [W-1:0] mq[$];
  int           mcnt;

  function automatic logic [W-1:0] mk(input int k);
    logic [31:0] instr, pc, alu;
    instr = 32'h2402_0005 + k;
    pc    = 32'h0000_3004 + 4 * k;
    alu   = 32'd5 + k;
    return {32'h0, 32'h0, alu, pc, instr};
  endfunction

  function automatic vec_t row(bit st, bit fl, bit iv, bit orr, logic [W-1:0] din,
                               bit e_rdy, bit e_val, logic [W-1:0] e_data, int e_cnt);
    vec_t v;
    v.st = st; v.fl = fl; v.iv = iv; v.orr = orr; v.din = din;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input bit st, input bit fl, input bit iv, input bit orr,
                       input logic [W-1:0] din);
    stall = st; flush = fl; in_valid = iv; out_ready = orr; in_data = din;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    reset = 1;
    #2;
    reset = 0;
    mq.delete();
    mcnt = 0;
  endtask

  function automatic bit m_ready(input bit st, input bit orr);
    if (SKID) return !st && (mq.size() < 2);
    return !st && (mq.size() == 0 || orr);
  endfunction

  task automatic m_edge(input bit st, input bit fl, input bit iv, input bit orr,
                        input bit rdy, input logic [W-1:0] din);
    bit pop, push;
    if (fl) begin
      if (mq.size() > 0 && mcnt < CMAX) mcnt++;
      mq.delete();
    end else if (!st) begin
      pop  = (mq.size() > 0) && orr;
      push = iv && rdy;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(din);
      if (pop && mq.size() == 0 && mcnt < CMAX) mcnt++;
    end
  endtask

  initial begin
    logic [W-1:0] pend;
    bit st, fl, iv, orr, rdy;
    logic [W-1:0] din;

    // Reset state while reset is held
    #1;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_data", out_data, '0);
    chk("rst_cnt", W'(bubble_cnt), W'(0));
    @(negedge clk);
    reset = 0;

    // Build up some state, then reset asynchronously between edges
    apply(0, 0, 1, 1, mk(0)); tick();
    apply(0, 0, 0, 1, '0);    tick();
    apply(0, 0, 1, 0, mk(1)); tick();
    chk("pre_async_valid", W'(out_valid), W'(1));
    chk("pre_async_cnt", W'(bubble_cnt), W'(1));
    #3 reset = 1;
    #1;
    chk("async_valid", W'(out_valid), W'(0));
    chk("async_data", out_data, '0);
    chk("async_cnt", W'(bubble_cnt), W'(0));
    #1 reset = 0;

    // Vector table: streaming, drain, idle, stall, stall+flush, flush empty
    tbl[0]  = row(0, 0, 1, 1, mk(0), 1, 1, mk(0), 0);
    tbl[1]  = row(0, 0, 1, 1, mk(1), 1, 1, mk(1), 0);
    tbl[2]  = row(0, 0, 1, 1, mk(2), 1, 1, mk(2), 0);
    tbl[3]  = row(0, 0, 1, 1, mk(4), 1, 1, mk(4), 0);
    tbl[4]  = row(0, 0, 0, 1, '0,    1, 0, '0,    1);
    tbl[5]  = row(0, 0, 0, 0, '0,    1, 0, '0,    1);
    tbl[6]  = row(0, 0, 1, 0, mk(5), 1, 1, mk(5), 1);
    tbl[7]  = row(1, 0, 1, 1, mk(3), 0, 1, mk(5), 1);
    tbl[8]  = row(1, 0, 1, 1, mk(3), 0, 1, mk(5), 1);
    tbl[9]  = row(0, 0, 1, 1, mk(3), 1, 1, mk(3), 1);
    tbl[10] = row(1, 1, 1, 1, mk(6), 0, 0, '0,    2);
    tbl[11] = row(0, 1, 1, 0, mk(7), 1, 0, '0,    2);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].orr, tbl[i].din);
      chk($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(tbl[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(tbl[i].e_val));
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_data);
      chk($sformatf("vec%0d_cnt", i), W'(bubble_cnt), W'(tbl[i].e_cnt));
    end

    // Backpressure: held output, skid absorption, in-order release
    do_reset();
    apply(0, 0, 1, 0, mk(8));
    chk("bp0_rdy", W'(in_ready), W'(1));
    tick();
    chk("bp0_data", out_data, mk(8));
    chk("bp0_pc", W'(field_sel(out_data, F_PC)), W'(32'h0000_3024));
    apply(0, 0, 1, 0, mk(9));
    chk("bp1_rdy", W'(in_ready), W'(SKID));
    tick();
    chk("bp1_data", out_data, mk(8));
    pend = SKID ? mk(10) : mk(9);
    for (int c = 2; c < 4; c++) begin
      apply(0, 0, 1, 0, pend);
      chk($sformatf("bp%0d_rdy", c), W'(in_ready), W'(0));
      tick();
      chk($sformatf("bp%0d_data", c), out_data, mk(8));
    end
    apply(0, 0, 1, 1, pend);
    chk("bp4_rdy", W'(in_ready), W'(!SKID));
    tick();
    chk("bp4_valid", W'(out_valid), W'(1));
    chk("bp4_data", out_data, mk(9));
    apply(0, 0, SKID, 1, SKID ? mk(10) : '0);
    chk("bp5_rdy", W'(in_ready), W'(1));
    tick();
    chk("bp5_valid", W'(out_valid), W'(SKID));
    chk("bp5_data", out_data, SKID ? mk(10) : '0);
    apply(0, 0, 0, 1, '0);
    tick();
    chk("bp6_valid", W'(out_valid), W'(0));
    chk("bp6_cnt", W'(bubble_cnt), W'(1));

    // Counter saturation over 20 bubble events
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      apply(0, 0, 1, 1, mk(k)); tick();
      apply(0, 0, 0, 1, '0);    tick();
      chk($sformatf("sat%0d_cnt", k), W'(bubble_cnt), W'((k > CMAX) ? CMAX : k));
    end

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      st  = ($urandom % 5) == 0;
      fl  = ($urandom % 16) == 0;
      iv  = ($urandom % 4) != 0;
      orr = ($urandom % 3) != 0;
      din = {$urandom, $urandom, $urandom, $urandom, $urandom};
      apply(st, fl, iv, orr, din);
      rdy = m_ready(st, orr);
      chk("rnd_in_ready", W'(in_ready), W'(rdy));
      tick();
      m_edge(st, fl, iv, orr, rdy, din);
      chk("rnd_out_valid", W'(out_valid), W'(mq.size() > 0));
      chk("rnd_out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
      chk("rnd_cnt", W'(bubble_cnt), W'(mcnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
